// File: rtl/sq_deq_policy_pkg.sv
// Shared store-queue definitions: default geometry, pointer width and the
// dequeue FSM state encoding.
package sq_deq_policy_pkg;

  localparam int unsigned SQ_QUEUE_SIZE     = 8;
  localparam int unsigned SQ_QUEUE_SIZE_LOG = 3;
  // Pointers carry one extra wrap bit above the index.
  localparam int unsigned SQ_PTR_W          = SQ_QUEUE_SIZE_LOG + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitAck = 2'd2
  } deq_state_e;

endpackage

// File: rtl/sq_deq_policy_if.sv
// Signal bundle between the store queue (master) and its dequeue policy (slave).
interface sq_deq_policy_if
  import sq_deq_policy_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE     = SQ_QUEUE_SIZE,
  parameter int unsigned QUEUE_SIZE_LOG = SQ_QUEUE_SIZE_LOG
);

  logic [QUEUE_SIZE_LOG:0]   enq_ptr;
  logic                      commit_valid;
  logic                      mem_req_ready;
  logic                      mem_ack;
  logic                      mem_req_valid;
  logic [QUEUE_SIZE_LOG-1:0] mem_req_idx;
  logic                      deq_fire;
  logic [QUEUE_SIZE_LOG:0]   deq_ptr;
  logic [QUEUE_SIZE-1:0]     deq_ptr_oh;
  logic [QUEUE_SIZE_LOG:0]   commit_ptr;
  logic                      sq_full;
  logic                      sq_empty;
  logic [QUEUE_SIZE_LOG:0]   sq_count;
  logic                      commit_err;

  modport master (
    output enq_ptr, commit_valid, mem_req_ready, mem_ack,
    input  mem_req_valid, mem_req_idx, deq_fire, deq_ptr, deq_ptr_oh, commit_ptr,
           sq_full, sq_empty, sq_count, commit_err
  );

  modport slave (
    input  enq_ptr, commit_valid, mem_req_ready, mem_ack,
    output mem_req_valid, mem_req_idx, deq_fire, deq_ptr, deq_ptr_oh, commit_ptr,
           sq_full, sq_empty, sq_count, commit_err
  );

endinterface

// File: rtl/queue_occupancy.sv
// Full/empty/count derived from a pair of wrap-bit pointers; shared by the
// in-order queues.
module queue_occupancy #(
  parameter int unsigned QUEUE_SIZE     = 8,
  parameter int unsigned QUEUE_SIZE_LOG = 3
) (
  input  logic [QUEUE_SIZE_LOG:0] enq_ptr_i,
  input  logic [QUEUE_SIZE_LOG:0] deq_ptr_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [QUEUE_SIZE_LOG:0] count_o
);

  localparam int unsigned PtrW = QUEUE_SIZE_LOG + 1;

  always_comb begin
    count_o = enq_ptr_i - deq_ptr_i;
    empty_o = (enq_ptr_i == deq_ptr_i);
    // Same index, opposite wrap bit is exactly a distance of QUEUE_SIZE.
    full_o  = (count_o == PtrW'(QUEUE_SIZE));
  end

endmodule

// File: rtl/sq_deq_policy.sv
// Store-queue dequeue policy: tracks the commit and dequeue pointers and
// writes committed entries to the dcache one at a time.
module sq_deq_policy
  import sq_deq_policy_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE     = SQ_QUEUE_SIZE,
  parameter int unsigned QUEUE_SIZE_LOG = SQ_QUEUE_SIZE_LOG
) (
  input logic            clock,
  input logic            reset,
  sq_deq_policy_if.slave bus
);

  localparam int unsigned PtrW = QUEUE_SIZE_LOG + 1;

  logic [PtrW-1:0]       deq_ptr_q, deq_ptr_d;
  logic [PtrW-1:0]       commit_ptr_q, commit_ptr_d;
  deq_state_e            state_q, state_d;
  logic                  commit_ok;
  logic                  ack_in_wait;
  logic                  deq_fire;
  logic                  req_valid;
  logic [QUEUE_SIZE-1:0] deq_oh;
  logic                  occ_full, occ_empty;
  logic [PtrW-1:0]       occ_count;

  always_comb begin
    commit_ok    = bus.commit_valid && (commit_ptr_q != bus.enq_ptr);
    commit_ptr_d = commit_ptr_q;
    if (commit_ok) begin
      commit_ptr_d = commit_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid   = 1'b0;
    ack_in_wait = 1'b0;
    case (state_q)
      StIdle: begin
        if (commit_ptr_q != deq_ptr_q) state_d = StReq;
      end
      StReq: begin
        req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (bus.mem_ack) begin
          ack_in_wait = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A reset abandons any in-flight write, so an ack in that cycle must not retire.
  assign deq_fire  = ack_in_wait && !reset;
  assign deq_ptr_d = deq_fire ? deq_ptr_q + PtrW'(1) : deq_ptr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      deq_ptr_q    <= '0;
      commit_ptr_q <= '0;
    end else begin
      state_q      <= state_d;
      deq_ptr_q    <= deq_ptr_d;
      commit_ptr_q <= commit_ptr_d;
    end
  end

  always_comb begin
    deq_oh = '0;
    deq_oh[deq_ptr_q[QUEUE_SIZE_LOG-1:0]] = 1'b1;
  end

  queue_occupancy #(
    .QUEUE_SIZE    (QUEUE_SIZE),
    .QUEUE_SIZE_LOG(QUEUE_SIZE_LOG)
  ) u_occupancy (
    .enq_ptr_i(bus.enq_ptr),
    .deq_ptr_i(deq_ptr_q),
    .full_o   (occ_full),
    .empty_o  (occ_empty),
    .count_o  (occ_count)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_idx   = deq_ptr_q[QUEUE_SIZE_LOG-1:0];
  assign bus.deq_fire      = deq_fire;
  assign bus.deq_ptr       = deq_ptr_q;
  assign bus.deq_ptr_oh    = deq_oh;
  assign bus.commit_ptr    = commit_ptr_q;
  assign bus.sq_full       = occ_full;
  assign bus.sq_empty      = occ_empty;
  assign bus.sq_count      = occ_count;
  assign bus.commit_err    = bus.commit_valid && !commit_ok && !reset;

endmodule

// File: tb/tb_sq_deq_policy.sv
// Directed bench for sq_deq_policy with hand-computed expectations.
module tb_sq_deq_policy;
  import sq_deq_policy_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [3:0] model;

  sq_deq_policy_if #(.QUEUE_SIZE(8), .QUEUE_SIZE_LOG(3)) bus ();

  sq_deq_policy #(.QUEUE_SIZE(8), .QUEUE_SIZE_LOG(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.enq_ptr       = '0;
    bus.commit_valid  = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_ack       = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // One enqueue/commit/write/ack round; model holds the expected deq_ptr.
  task automatic do_round();
    int waited;
    logic [7:0] exp_oh;
    bus.enq_ptr      = 4'(model + 4'd1);
    bus.commit_valid = 1'b1;
    tick();
    bus.commit_valid = 1'b0;
    check("rnd_commit_ptr", 32'(bus.commit_ptr), 32'(4'(model + 4'd1)));
    bus.mem_req_ready = 1'b1;
    waited = 0;
    while (!bus.mem_req_valid && waited < 8) begin
      tick();
      waited++;
    end
    check("rnd_req_valid", 32'(bus.mem_req_valid), 1);
    check("rnd_req_idx", 32'(bus.mem_req_idx), 32'(model[2:0]));
    tick();
    bus.mem_ack = 1'b1;
    #1;
    check("rnd_deq_fire", 32'(bus.deq_fire), 1);
    tick();
    bus.mem_ack       = 1'b0;
    bus.mem_req_ready = 1'b0;
    model  = 4'(model + 4'd1);
    exp_oh = 8'b1 << model[2:0];
    #1;
    check("rnd_deq_ptr", 32'(bus.deq_ptr), 32'(model));
    check("rnd_deq_oh", 32'(bus.deq_ptr_oh), 32'(exp_oh));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model    = '0;
    do_reset();
    tick();

    check("rst_deq_ptr", 32'(bus.deq_ptr), 0);
    check("rst_commit_ptr", 32'(bus.commit_ptr), 0);
    check("rst_req_valid", 32'(bus.mem_req_valid), 0);
    check("rst_deq_fire", 32'(bus.deq_fire), 0);
    check("rst_commit_err", 32'(bus.commit_err), 0);
    check("rst_empty", 32'(bus.sq_empty), 1);
    check("rst_deq_oh", 32'(bus.deq_ptr_oh), 1);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));

    // Commit with nothing enqueued is illegal.
    bus.commit_valid = 1'b1;
    #1;
    check("err_pulse", 32'(bus.commit_err), 1);
    tick();
    bus.commit_valid = 1'b0;
    #1;
    check("err_commit_hold", 32'(bus.commit_ptr), 0);
    check("err_clear", 32'(bus.commit_err), 0);

    // Enqueued but uncommitted entries never trigger a write.
    bus.enq_ptr = 4'd3;
    #1;
    check("occ_count3", 32'(bus.sq_count), 3);
    check("occ_empty0", 32'(bus.sq_empty), 0);
    check("occ_full0", 32'(bus.sq_full), 0);
    repeat (3) tick();
    check("nocommit_req", 32'(bus.mem_req_valid), 0);

    // Single commit through to retire.
    do_reset();
    bus.enq_ptr      = 4'd1;
    bus.commit_valid = 1'b1;
    tick();
    bus.commit_valid = 1'b0;
    check("one_commit_ptr", 32'(bus.commit_ptr), 1);
    check("one_req_latency", 32'(bus.mem_req_valid), 0);
    bus.mem_req_ready = 1'b1;
    tick();
    check("one_req_valid", 32'(bus.mem_req_valid), 1);
    check("one_req_idx", 32'(bus.mem_req_idx), 0);
    tick();
    check("one_wait_req", 32'(bus.mem_req_valid), 0);
    check("one_wait_fire", 32'(bus.deq_fire), 0);
    tick();
    bus.mem_ack = 1'b1;
    #1;
    check("one_fire", 32'(bus.deq_fire), 1);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("one_deq_ptr", 32'(bus.deq_ptr), 1);
    check("one_fire_clear", 32'(bus.deq_fire), 0);
    check("one_empty", 32'(bus.sq_empty), 1);
    check("one_deq_oh", 32'(bus.deq_ptr_oh), 2);

    // Stray ack while idle.
    bus.mem_ack = 1'b1;
    #1;
    check("idle_ack_fire", 32'(bus.deq_fire), 0);
    tick();
    bus.mem_ack       = 1'b0;
    bus.mem_req_ready = 1'b0;
    #1;
    check("idle_ack_deq", 32'(bus.deq_ptr), 1);

    // Nine rounds cross the wrap of an 8-entry queue.
    do_reset();
    model = '0;
    for (int r = 0; r < 9; r++) do_round();
    check("wrap_deq_ptr", 32'(bus.deq_ptr), 9);

    // Full queue, commit and retire in the same cycle, then commit limit.
    do_reset();
    bus.enq_ptr = 4'd8;
    #1;
    check("full_flag", 32'(bus.sq_full), 1);
    check("full_count", 32'(bus.sq_count), 8);
    check("full_empty", 32'(bus.sq_empty), 0);
    bus.commit_valid  = 1'b1;
    bus.mem_req_ready = 1'b1;
    repeat (3) tick();
    check("sim_commit3", 32'(bus.commit_ptr), 3);
    bus.mem_ack = 1'b1;
    #1;
    check("sim_fire", 32'(bus.deq_fire), 1);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("sim_commit4", 32'(bus.commit_ptr), 4);
    check("sim_deq1", 32'(bus.deq_ptr), 1);
    check("sim_count", 32'(bus.sq_count), 7);
    repeat (4) tick();
    check("lim_commit8", 32'(bus.commit_ptr), 8);
    check("lim_err", 32'(bus.commit_err), 1);
    tick();
    bus.commit_valid = 1'b0;
    #1;
    check("lim_hold", 32'(bus.commit_ptr), 8);

    // Reset while waiting for the ack drops the write.
    do_reset();
    bus.enq_ptr      = 4'd1;
    bus.commit_valid = 1'b1;
    tick();
    bus.commit_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    tick();
    check("abort_in_wait", 32'(dut.state_q), 32'(StWaitAck));
    reset       = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    check("abort_fire_rst", 32'(bus.deq_fire), 0);
    tick();
    reset = 1'b0;
    #1;
    check("abort_fire_post", 32'(bus.deq_fire), 0);
    check("abort_state", 32'(dut.state_q), 32'(StIdle));
    tick();
    bus.mem_ack = 1'b0;
    #1;
    check("abort_deq_ptr", 32'(bus.deq_ptr), 0);
    check("abort_state2", 32'(dut.state_q), 32'(StIdle));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sq_deq_policy.md
SQ_DEQ_POLICY -- requirements
Module: sq_deq_policy

Interface
REQ-001 Parameter QUEUE_SIZE, default 8, number of store-queue entries (power of two).
REQ-002 Parameter QUEUE_SIZE_LOG, default 3, log2(QUEUE_SIZE); all pointers are QUEUE_SIZE_LOG+1 bits wide (MSB = wrap bit).
REQ-003 Port list (name, direction, width, meaning):
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- enq_ptr, in, QUEUE_SIZE_LOG+1: enqueue pointer from the enqueue-side pointer policy.
- commit_valid, in, 1: ROB commits the oldest uncommitted store this cycle.
- mem_req_ready, in, 1: dcache accepts the write request.
- mem_ack, in, 1: dcache write complete (single-cycle pulse).
- mem_req_valid, out, 1: write request for entry mem_req_idx.
- mem_req_idx, out, QUEUE_SIZE_LOG: queue index being written (= deq_ptr low bits).
- deq_fire, out, 1: entry at deq_ptr retires this cycle; the queue clears that entry's valid bit.
- deq_ptr, out, QUEUE_SIZE_LOG+1: dequeue pointer.
- deq_ptr_oh, out, QUEUE_SIZE: one-hot of deq_ptr low bits.
- commit_ptr, out, QUEUE_SIZE_LOG+1: first uncommitted entry.
- sq_full, out, 1: queue full.
- sq_empty, out, 1: queue empty.
- sq_count, out, QUEUE_SIZE_LOG+1: occupied entries.
- commit_err, out, 1: illegal commit pulse.

Function
REQ-004 sq_count SHALL equal (enq_ptr - deq_ptr) modulo 2^(QUEUE_SIZE_LOG+1), combinational from current inputs and registers.
REQ-005 sq_empty SHALL be 1 iff enq_ptr == deq_ptr (all bits); sq_full SHALL be 1 iff low bits are equal and wrap bits differ.
REQ-006 deq_ptr_oh SHALL have exactly one bit set, at index deq_ptr[QUEUE_SIZE_LOG-1:0].
REQ-007 On commit_valid with commit_ptr != enq_ptr, commit_ptr SHALL increment by 1 at the next edge, wrapping through the MSB.
REQ-008 On commit_valid with commit_ptr == enq_ptr, commit_ptr SHALL hold and commit_err SHALL pulse high combinationally in that cycle.
REQ-009 FSM states IDLE, REQ, WAIT_ACK.
- IDLE -> REQ when commit_ptr != deq_ptr.
- REQ -> WAIT_ACK when mem_req_ready = 1.
- WAIT_ACK -> IDLE when mem_ack = 1.
- Every other condition holds the current state.
REQ-010 mem_req_valid SHALL be 1 exactly while in REQ; mem_req_idx SHALL be stable while in REQ and WAIT_ACK.
REQ-011 deq_fire SHALL equal (state == WAIT_ACK && mem_ack); deq_ptr SHALL increment by 1 at that edge.
REQ-012 mem_ack outside WAIT_ACK SHALL be ignored.
REQ-013 Latency: commit at edge N makes commit_ptr visible after N; if idle, mem_req_valid rises after edge N+1.
REQ-014 Simultaneous commit_valid and deq_fire SHALL both take effect in the same cycle.
REQ-015 Flush SHALL NOT affect this block; a flush only moves enq_ptr, which never drops below commit_ptr.
REQ-016 commit_ptr SHALL never pass enq_ptr, and deq_ptr SHALL never pass commit_ptr, including across wrap.

Reset
REQ-017 With reset high at an edge:
- deq_ptr and commit_ptr SHALL become 0.
- The FSM SHALL become IDLE.
- mem_req_valid, deq_fire and commit_err SHALL be 0 in the following cycle.
REQ-018 A reset in REQ or WAIT_ACK SHALL abandon the in-flight request without asserting deq_fire.

Structure
REQ-019 The FSM state enumeration and the pointer-width constant SHALL live in the shared package, alongside the existing global defines.
REQ-020 The full/empty/count comparison SHALL be a sub-module named queue_occupancy, parameterised identically and reusable by other in-order queues.

Verification
REQ-021 Reset, then enq_ptr = 3 with no commit -> sq_count = 3, sq_empty = 0, mem_req_valid stays 0.
REQ-022 enq_ptr = 1, commit_valid one cycle, mem_req_ready = 1, mem_ack two cycles later:
- commit_ptr becomes 1.
- mem_req_valid goes high after one more edge, with mem_req_idx = 0.
- deq_fire pulses once, and deq_ptr becomes 1.
REQ-023 enq_ptr = 0, commit_valid = 1 -> commit_err = 1 and commit_ptr stays 0.
REQ-024 Drive 9 enqueue/commit/ack rounds with QUEUE_SIZE = 8:
- deq_ptr goes 7 -> 8 (wrap bit set) and deq_ptr_oh returns to bit 0.
- At enq_ptr = 8, deq_ptr = 0: sq_full = 1.
REQ-025 Assert reset while in WAIT_ACK, then pulse mem_ack -> deq_fire stays 0, state is IDLE and deq_ptr = 0.
